pid_gain_uart_rx: RTL and testbench
===================================

Name: pid_gain_uart_rx

Overview:
- Host-to-FPGA UART command receiver; the return path of the PID telemetry UART link.
- Deserialises 8N1 bytes on uart_serial_rx and parses 5-byte gain-write frames.
- Holds the six PID gain registers (tachometer and wall, unsigned 8.8) that feed the pid_controller k_p/k_i/k_d inputs, replacing constant or push-button tuning.

Parameters:
- CLKS_PER_BIT, 1085, clk cycles per UART bit (115200 baud at 125 MHz).
- GAIN_WIDTH, 16, gain register width (8 integer + 8 fraction bits).
- KP_TACH_RST, 16'h0800, reset value of k_p_tach.
- KP_WALL_RST, 16'h0100, reset value of k_p_wall; all other gains reset to 0.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, maximum idle gap between bytes of one frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- uart_serial_rx  in  1  asynchronous serial input; idles high.
- k_p_tach, k_i_tach, k_d_tach  out  GAIN_WIDTH each  tachometer loop gains.
- k_p_wall, k_i_wall, k_d_wall  out  GAIN_WIDTH each  wall loop gains.
- gain_update  out  1  one-cycle pulse when a gain register is written.
- gain_addr  out  8  address of the last register written.
- frame_err_cnt  out  8  saturating count of stop-bit errors.
- cksum_err_cnt  out  8  saturating count of checksum failures.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Gains go to their reset values; gain_update=0; gain_addr=0; both counters=0.
  - Both FSMs return to IDLE/SYNC. This also applies mid-byte or mid-frame; a partial frame is discarded.
- Input sync: uart_serial_rx passes through a 2-FF synchroniser before any use. Pre-reset synchroniser state is 1.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised falling edge.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample.
    - Sample high -> IDLE (glitch; no count).
    - Sample low -> DATA.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High -> one-cycle byte_valid with the byte.
    - Low -> frame_err pulse (frame_err_cnt++, saturating at 255), then return to IDLE only once the line is high.
- Frame format, in byte order:
  - 0xA5 (sync), ADDR, DATA_HI, DATA_LO, CKSUM.
  - CKSUM = ADDR ^ DATA_HI ^ DATA_LO.
- Parser FSM states: SYNC, ADDR, HI, LO, CK.
  - SYNC discards every byte other than 0xA5.
  - A frame_err in any state sends the parser to SYNC.
- Address map: 0x00 kp_tach, 0x01 ki_tach, 0x02 kd_tach, 0x10 kp_wall, 0x11 ki_wall, 0x12 kd_wall.
- Checksum byte handling, in the cycle after its byte_valid:
  - Checksum mismatch -> cksum_err_cnt++ (saturating); no write.
  - Match with a mapped ADDR -> target register = {DATA_HI, DATA_LO}, gain_addr = ADDR, gain_update=1 for one cycle. The register and pulse change in the same cycle.
  - Match with an unmapped ADDR -> silently ignored; no pulse, no count.
  - In all three cases the parser returns to SYNC.
- Latency: gain visible 2 clk after the stop-bit sample of CKSUM (byte_valid register, then write).
- Back-to-back frames with no idle gap are accepted.
- A 0xA5 received mid-frame is treated as data, not as a resync.
- Gains hold their value indefinitely between writes.

Optional Feature:
- Macro: PID_GAIN_RX_TIMEOUT_EN.
- Defined: a counter clears on each byte_valid and runs while the parser is not in SYNC. Reaching TIMEOUT_CLKS forces the parser to SYNC; no counter is incremented.
- Undefined: no timeout logic; a stalled partial frame waits indefinitely for its remaining bytes.

Decomposition:
- Package pid_gain_pkg:
  - SYNC_BYTE = 8'hA5.
  - Address localparams ADDR_KP_TACH .. ADDR_KD_WALL.
  - typedef enum for parser states; typedef enum for bit states.
  - typedef logic [15:0] gain_t.
- Sub-module uart_rx: synchroniser plus bit FSM, outputs byte_valid, byte_data, frame_err.
- Top level holds the parser, gain registers and counters.

Test Plan (CLKS_PER_BIT=16 for sim):
- Reset: hold reset low 3 cycles -> k_p_tach=16'h0800, k_p_wall=16'h0100, all other gains 0, counters 0, gain_update 0.
- Valid write: send A5 01 12 34 27 -> k_i_tach=16'h1234 exactly 2 clk after the last stop-bit sample; gain_update pulses 1 cycle; gain_addr=8'h01.
- Bad checksum: send A5 10 00 80 00 -> k_p_wall stays 16'h0100; cksum_err_cnt=1; no gain_update. A following A5 10 00 80 90 sets k_p_wall=16'h0080.
- Framing error: drive a byte with stop bit low between ADDR and HI -> frame_err_cnt=1, parser back in SYNC. Next full valid frame is accepted.
- Glitch and reset mid-frame:
  - 4-cycle low pulse on rx -> no byte produced, counters unchanged.
  - Reset asserted after A5 11 -> next bytes 00 05 14 are ignored (not treated as HI/LO/CK).
- Timeout (macro defined): send A5 02, then idle 21*CLKS_PER_BIT cycles, then 00 10 12 -> no write. A subsequent full frame A5 02 00 10 12 sets k_d_tach=16'h0010.

Source files
------------

// File: rtl/pid_gain_pkg.sv
// Shared types and constants for the PID gain command receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pid_gain_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;

  localparam logic [7:0] ADDR_KP_TACH = 8'h00;
  localparam logic [7:0] ADDR_KI_TACH = 8'h01;
  localparam logic [7:0] ADDR_KD_TACH = 8'h02;
  localparam logic [7:0] ADDR_KP_WALL = 8'h10;
  localparam logic [7:0] ADDR_KI_WALL = 8'h11;
  localparam logic [7:0] ADDR_KD_WALL = 8'h12;

  typedef enum logic [2:0] {P_SYNC, P_ADDR, P_HI, P_LO, P_CK} parse_state_t;
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;

  typedef logic [15:0] gain_t;

  function automatic logic is_gain_addr(input logic [7:0] a);
    return (a == ADDR_KP_TACH) || (a == ADDR_KI_TACH) || (a == ADDR_KD_TACH) ||
           (a == ADDR_KP_WALL) || (a == ADDR_KI_WALL) || (a == ADDR_KD_WALL);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser plus start/data/stop bit FSM.
// Latency: byte_valid/frame_err pulse one clk after the stop-bit sample.
// Backpressure: none; the consumer must take byte_data on the byte_valid cycle.
// Ports: clk, reset (sync, active-low), serial (async line, idles high),
//        byte_valid/byte_data (received byte), frame_err (stop bit was low).
module uart_rx
  import pid_gain_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          meta, rx_s, rx_d;
  bit_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          wait_high, wait_high_n;
  logic          bv_n, fe_n;

  assign byte_data = shreg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= B_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      wait_high  <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      meta       <= serial;
      rx_s       <= meta;
      rx_d       <= rx_s;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      wait_high  <= wait_high_n;
      byte_valid <= bv_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    wait_high_n = wait_high;
    bv_n        = 1'b0;
    fe_n        = 1'b0;
    case (state)
      B_IDLE: begin
        cnt_n = '0;
        if (rx_d && !rx_s) state_n = B_START;
      end
      B_START: begin
        // Mid-start-bit check rejects short glitches.
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt == FULL) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = B_STOP;
        end
      end
      B_STOP: begin
        if (wait_high) begin
          // After a bad stop bit, hold off until the line is back at idle so a
          // long break is not mistaken for a new start bit.
          cnt_n = '0;
          if (rx_s) begin
            wait_high_n = 1'b0;
            state_n     = B_IDLE;
          end
        end else if (cnt == FULL) begin
          cnt_n = '0;
          if (rx_s) begin
            bv_n    = 1'b1;
            state_n = B_IDLE;
          end else begin
            fe_n        = 1'b1;
            wait_high_n = 1'b1;
          end
        end
      end
      default: state_n = B_IDLE;
    endcase
  end

endmodule

// File: rtl/pid_gain_uart_rx.sv
// PID gain command receiver: parses A5/ADDR/HI/LO/CKSUM frames into six gain registers.
// Latency: gain and gain_update change 2 clk after the checksum stop-bit sample.
// Backpressure: none; frames are consumed at line rate, back-to-back allowed.
// Ports: clk, reset (sync, active-low), uart_serial_rx; k_{p,i,d}_{tach,wall} gains,
//        gain_update pulse, gain_addr, frame_err_cnt / cksum_err_cnt (saturating).
// Option: define PID_GAIN_RX_TIMEOUT_EN to abandon frames stalled for TIMEOUT_CLKS.
module pid_gain_uart_rx
  import pid_gain_pkg::*;
#(
  parameter int                    CLKS_PER_BIT = 1085,
  parameter int                    GAIN_WIDTH   = 16,
  parameter logic [GAIN_WIDTH-1:0] KP_TACH_RST  = 16'h0800,
  parameter logic [GAIN_WIDTH-1:0] KP_WALL_RST  = 16'h0100
`ifdef PID_GAIN_RX_TIMEOUT_EN
  ,
  parameter int                    TIMEOUT_CLKS = 20 * CLKS_PER_BIT
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_serial_rx,
  output logic [GAIN_WIDTH-1:0] k_p_tach,
  output logic [GAIN_WIDTH-1:0] k_i_tach,
  output logic [GAIN_WIDTH-1:0] k_d_tach,
  output logic [GAIN_WIDTH-1:0] k_p_wall,
  output logic [GAIN_WIDTH-1:0] k_i_wall,
  output logic [GAIN_WIDTH-1:0] k_d_wall,
  output logic                  gain_update,
  output logic [7:0]            gain_addr,
  output logic [7:0]            frame_err_cnt,
  output logic [7:0]            cksum_err_cnt
);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .serial    (uart_serial_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  parse_state_t pstate, pstate_n;
  logic [7:0]   addr_q, hi_q, lo_q;
  logic         wr_en, ck_bad, timed_out;
  gain_t        wdata;

  assign wdata = {hi_q, lo_q};

`ifdef PID_GAIN_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!reset || byte_valid || pstate == P_SYNC) to_cnt <= '0;
    else                                           to_cnt <= to_cnt + 1'b1;
  end

  assign timed_out = (pstate != P_SYNC) && (to_cnt == TW'(TIMEOUT_CLKS - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    pstate_n = pstate;
    wr_en    = 1'b0;
    ck_bad   = 1'b0;
    if (frame_err) begin
      pstate_n = P_SYNC;
    end else if (byte_valid) begin
      case (pstate)
        P_SYNC: if (byte_data == SYNC_BYTE) pstate_n = P_ADDR;
        P_ADDR: pstate_n = P_HI;
        P_HI:   pstate_n = P_LO;
        P_LO:   pstate_n = P_CK;
        P_CK: begin
          pstate_n = P_SYNC;
          if ((addr_q ^ hi_q ^ lo_q) != byte_data) ck_bad = 1'b1;
          else                                     wr_en  = is_gain_addr(addr_q);
        end
        default: pstate_n = P_SYNC;
      endcase
    end else if (timed_out) begin
      pstate_n = P_SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pstate        <= P_SYNC;
      addr_q        <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      k_p_tach      <= KP_TACH_RST;
      k_i_tach      <= '0;
      k_d_tach      <= '0;
      k_p_wall      <= KP_WALL_RST;
      k_i_wall      <= '0;
      k_d_wall      <= '0;
      gain_update   <= 1'b0;
      gain_addr     <= '0;
      frame_err_cnt <= '0;
      cksum_err_cnt <= '0;
    end else begin
      pstate      <= pstate_n;
      gain_update <= wr_en;
      if (byte_valid) begin
        case (pstate)
          P_ADDR:  addr_q <= byte_data;
          P_HI:    hi_q   <= byte_data;
          P_LO:    lo_q   <= byte_data;
          default: ;
        endcase
      end
      if (wr_en) begin
        gain_addr <= addr_q;
        case (addr_q)
          ADDR_KP_TACH: k_p_tach <= GAIN_WIDTH'(wdata);
          ADDR_KI_TACH: k_i_tach <= GAIN_WIDTH'(wdata);
          ADDR_KD_TACH: k_d_tach <= GAIN_WIDTH'(wdata);
          ADDR_KP_WALL: k_p_wall <= GAIN_WIDTH'(wdata);
          ADDR_KI_WALL: k_i_wall <= GAIN_WIDTH'(wdata);
          ADDR_KD_WALL: k_d_wall <= GAIN_WIDTH'(wdata);
          default: ;
        endcase
      end
      if (frame_err && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 1'b1;
      if (ck_bad && cksum_err_cnt != 8'hFF)    cksum_err_cnt <= cksum_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_gain_uart_rx.sv
module tb_pid_gain_uart_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] k_p_tach, k_i_tach, k_d_tach, k_p_wall, k_i_wall, k_d_wall;
  logic        gain_update;
  logic [7:0]  gain_addr, frame_err_cnt, cksum_err_cnt;

  pid_gain_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_serial_rx(rx),
    .k_p_tach      (k_p_tach),
    .k_i_tach      (k_i_tach),
    .k_d_tach      (k_d_tach),
    .k_p_wall      (k_p_wall),
    .k_i_wall      (k_i_wall),
    .k_d_wall      (k_d_wall),
    .gain_update   (gain_update),
    .gain_addr     (gain_addr),
    .frame_err_cnt (frame_err_cnt),
    .cksum_err_cnt (cksum_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reg_of(input logic [7:0] a);
    case (a)
      8'h00:   return k_p_tach;
      8'h01:   return k_i_tach;
      8'h02:   return k_d_tach;
      8'h10:   return k_p_wall;
      8'h11:   return k_i_wall;
      8'h12:   return k_d_wall;
      default: return 16'hxxxx;
    endcase
  endfunction

  // Scoreboard: each gain_update must match the oldest expected write.
  logic prev_upd = 1'b0;
  wr_t  e;
  always @(negedge clk) begin
    if (reset && gain_update) begin
      check("pulse_one_cycle", {31'b0, prev_upd}, 32'd0);
      check("update_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("gain_addr", {24'b0, gain_addr}, {24'b0, e.a});
        check("gain_value", {16'b0, reg_of(e.a)}, {16'b0, e.d});
      end
    end
    prev_upd = gain_update;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] ck);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    send_byte(ck, 1'b1);
  endtask

  initial begin
    // Reset state
    idle(3);
    reset = 1'b1;
    idle(1);
    check("rst_kp_tach", {16'b0, k_p_tach}, 32'h0800);
    check("rst_ki_tach", {16'b0, k_i_tach}, 32'h0000);
    check("rst_kd_tach", {16'b0, k_d_tach}, 32'h0000);
    check("rst_kp_wall", {16'b0, k_p_wall}, 32'h0100);
    check("rst_ki_wall", {16'b0, k_i_wall}, 32'h0000);
    check("rst_kd_wall", {16'b0, k_d_wall}, 32'h0000);
    check("rst_frame_cnt", {24'b0, frame_err_cnt}, 32'd0);
    check("rst_cksum_cnt", {24'b0, cksum_err_cnt}, 32'd0);
    check("rst_update", {31'b0, gain_update}, 32'd0);
    check("rst_addr", {24'b0, gain_addr}, 32'd0);

    // Valid write
    exp_q.push_back({8'h01, 16'h1234});
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    idle(4);
    check("ki_tach_write", {16'b0, k_i_tach}, 32'h1234);
    check("addr_after_write", {24'b0, gain_addr}, 32'h01);

    // Bad checksum, then good frame
    send_frame(8'h10, 8'h00, 8'h80, 8'h00);
    idle(4);
    check("kp_wall_held", {16'b0, k_p_wall}, 32'h0100);
    check("cksum_cnt_1", {24'b0, cksum_err_cnt}, 32'd1);
    exp_q.push_back({8'h10, 16'h0080});
    send_frame(8'h10, 8'h00, 8'h80, 8'h90);
    idle(4);
    check("kp_wall_write", {16'b0, k_p_wall}, 32'h0080);

    // Framing error between ADDR and HI
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(3 * CPB);
    check("frame_cnt_1", {24'b0, frame_err_cnt}, 32'd1);
    // Parser must be in SYNC: these are all discarded
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(4);
    check("resync_no_cksum", {24'b0, cksum_err_cnt}, 32'd1);
    exp_q.push_back({8'h12, 16'h0007});
    send_frame(8'h12, 8'h00, 8'h07, 8'h15);
    idle(4);
    check("kd_wall_write", {16'b0, k_d_wall}, 32'h0007);

    // Glitch shorter than half a bit
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2 * CPB);
    check("glitch_frame_cnt", {24'b0, frame_err_cnt}, 32'd1);
    check("glitch_cksum_cnt", {24'b0, cksum_err_cnt}, 32'd1);

    // Reset mid-frame discards partial frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h14, 1'b1);
    idle(4);
    check("midrst_ki_wall", {16'b0, k_i_wall}, 32'h0000);
    check("midrst_kp_wall", {16'b0, k_p_wall}, 32'h0100);
    check("midrst_cksum", {24'b0, cksum_err_cnt}, 32'd0);
    check("midrst_frame", {24'b0, frame_err_cnt}, 32'd0);

    // 0xA5 inside a frame is data
    exp_q.push_back({8'h01, 16'hA5A5});
    send_frame(8'h01, 8'hA5, 8'hA5, 8'h01);
    idle(4);
    check("a5_as_data", {16'b0, k_i_tach}, 32'hA5A5);

    // Back-to-back frames
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h11, 16'h0005});
    send_frame(8'h00, 8'h12, 8'h34, 8'h26);
    send_frame(8'h11, 8'h00, 8'h05, 8'h14);
    idle(4);
    check("b2b_kp_tach", {16'b0, k_p_tach}, 32'h1234);
    check("b2b_ki_wall", {16'b0, k_i_wall}, 32'h0005);

    // Long stall inside a frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(21 * CPB);
`ifndef PID_GAIN_RX_TIMEOUT_EN
    exp_q.push_back({8'h02, 16'h0010});
`endif
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h12, 1'b1);
    idle(4);
`ifdef PID_GAIN_RX_TIMEOUT_EN
    check("timeout_no_write", {16'b0, k_d_tach}, 32'h0000);
    check("timeout_no_cksum", {24'b0, cksum_err_cnt}, 32'd0);
    exp_q.push_back({8'h02, 16'h0010});
    send_frame(8'h02, 8'h00, 8'h10, 8'h12);
    idle(4);
`endif
    check("kd_tach_write", {16'b0, k_d_tach}, 32'h0010);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
